// File: rtl/taxi_axi_rd_arb_if.sv
// AXI4 read-channel bundle (AR + R) carrying N requester lanes packed side by side.
// The arbiter uses the slave modport toward its requesters and the master modport downstream.
interface taxi_axi_rd_arb_if #(
  parameter int N      = 1,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 8
);
  logic [N*ID_W-1:0]   ar_id;
  logic [N*ADDR_W-1:0] ar_addr;
  logic [N*8-1:0]      ar_len;
  logic [N*3-1:0]      ar_size;
  logic [N*2-1:0]      ar_burst;
  logic [N-1:0]        ar_valid;
  logic [N-1:0]        ar_ready;
  logic [N*ID_W-1:0]   r_id;
  logic [N*DATA_W-1:0] r_data;
  logic [N*2-1:0]      r_resp;
  logic [N-1:0]        r_last;
  logic [N-1:0]        r_valid;
  logic [N-1:0]        r_ready;

  modport master (
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid, r_ready,
    input  ar_ready, r_id, r_data, r_resp, r_last, r_valid
  );

  modport slave (
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid, r_ready,
    output ar_ready, r_id, r_data, r_resp, r_last, r_valid
  );
endinterface

// File: rtl/taxi_axi_rd_arb.sv
// Round-robin AXI4 read arbiter: S_COUNT requesters share one master port, R routed by upper ID bits.
// Optional per-requester outstanding-burst limit is built when TAXI_AXI_RD_ARB_LIMIT_EN is defined.
module taxi_axi_rd_arb #(
  parameter int S_COUNT         = 4,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int S_ID_W          = 8,
  parameter int M_ID_W          = S_ID_W + $clog2(S_COUNT),
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                clk,
  input  logic                rst,
  taxi_axi_rd_arb_if.slave    s_if,
  taxi_axi_rd_arb_if.master   m_if
);
  localparam int IDX_W = $clog2(S_COUNT);
  localparam int SEL_W = M_ID_W - S_ID_W;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // m_ar_valid comes straight from the holding register and never looks at m_ar_ready;
  // s_ar_ready is a combinational grant that only rises for a requester already presenting valid.

  logic                ar_full_q, ar_full_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [M_ID_W-1:0]   ar_id_q, ar_id_d;
  logic [ADDR_W-1:0]   ar_addr_q, ar_addr_d;
  logic [7:0]          ar_len_q, ar_len_d;
  logic [2:0]          ar_size_q, ar_size_d;
  logic [1:0]          ar_burst_q, ar_burst_d;

  logic [S_COUNT-1:0]  elig;
  logic                grant_vld;
  logic [IDX_W-1:0]    grant_idx;
  logic                ar_free;
  logic                ar_hs;
  logic [SEL_W-1:0]    r_sel;

  // Search last+1, last+2, ... so the most recently served requester goes to the back.
  always_comb begin : arb
    int cand;
    cand      = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 1; k <= S_COUNT; k++) begin
      cand = (int'(last_q) + k) % S_COUNT;
      if (!grant_vld && elig[cand]) begin
        grant_vld = 1'b1;
        grant_idx = IDX_W'(cand);
      end
    end
  end

  assign ar_free = !ar_full_q || m_if.ar_ready[0];
  assign ar_hs   = grant_vld && ar_free && !rst;

  always_comb begin
    for (int i = 0; i < S_COUNT; i++) begin
      s_if.ar_ready[i] = ar_hs && (grant_idx == IDX_W'(i));
    end
  end

  always_comb begin
    ar_full_d  = ar_full_q && !m_if.ar_ready[0];
    last_d     = last_q;
    ar_id_d    = ar_id_q;
    ar_addr_d  = ar_addr_q;
    ar_len_d   = ar_len_q;
    ar_size_d  = ar_size_q;
    ar_burst_d = ar_burst_q;
    if (ar_hs) begin
      ar_full_d = 1'b1;
      last_d    = grant_idx;
      for (int i = 0; i < S_COUNT; i++) begin
        if (grant_idx == IDX_W'(i)) begin
          ar_id_d    = {SEL_W'(i), s_if.ar_id[i*S_ID_W +: S_ID_W]};
          ar_addr_d  = s_if.ar_addr[i*ADDR_W +: ADDR_W];
          ar_len_d   = s_if.ar_len[i*8 +: 8];
          ar_size_d  = s_if.ar_size[i*3 +: 3];
          ar_burst_d = s_if.ar_burst[i*2 +: 2];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ar_full_q  <= 1'b0;
      last_q     <= IDX_W'(S_COUNT - 1);
      ar_id_q    <= '0;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= '0;
    end else begin
      ar_full_q  <= ar_full_d;
      last_q     <= last_d;
      ar_id_q    <= ar_id_d;
      ar_addr_q  <= ar_addr_d;
      ar_len_q   <= ar_len_d;
      ar_size_q  <= ar_size_d;
      ar_burst_q <= ar_burst_d;
    end
  end

  assign m_if.ar_valid = ar_full_q;
  assign m_if.ar_id    = ar_id_q;
  assign m_if.ar_addr  = ar_addr_q;
  assign m_if.ar_len   = ar_len_q;
  assign m_if.ar_size  = ar_size_q;
  assign m_if.ar_burst = ar_burst_q;

  // R path is pure wiring; an index beyond S_COUNT is accepted and dropped.
  assign r_sel = m_if.r_id[M_ID_W-1:S_ID_W];

  always_comb begin
    m_if.r_ready[0] = 1'b1;
    for (int i = 0; i < S_COUNT; i++) begin
      s_if.r_valid[i] = m_if.r_valid[0] && (r_sel == SEL_W'(i));
      if (r_sel == SEL_W'(i)) begin
        m_if.r_ready[0] = s_if.r_ready[i];
      end
    end
  end

  assign s_if.r_id   = {S_COUNT{m_if.r_id[S_ID_W-1:0]}};
  assign s_if.r_data = {S_COUNT{m_if.r_data}};
  assign s_if.r_resp = {S_COUNT{m_if.r_resp}};
  assign s_if.r_last = {S_COUNT{m_if.r_last[0]}};

`ifdef TAXI_AXI_RD_ARB_LIMIT_EN
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [CNT_W-1:0]   cnt_q [S_COUNT];
  logic [CNT_W-1:0]   cnt_d [S_COUNT];
  logic [S_COUNT-1:0] cnt_inc;
  logic [S_COUNT-1:0] cnt_dec;
  logic               r_hs_last;

  assign r_hs_last = m_if.r_valid[0] && m_if.r_ready[0] && m_if.r_last[0];

  always_comb begin
    for (int i = 0; i < S_COUNT; i++) begin
      elig[i] = s_if.ar_valid[i] && (cnt_q[i] < CNT_W'(MAX_OUTSTANDING));
    end
  end

  // Same-cycle issue and completion on one index cancel; a stray completion at 0 is ignored.
  always_comb begin
    for (int i = 0; i < S_COUNT; i++) begin
      cnt_inc[i] = ar_hs && (grant_idx == IDX_W'(i));
      cnt_dec[i] = r_hs_last && (r_sel == SEL_W'(i));
      cnt_d[i]   = cnt_q[i];
      if (cnt_inc[i] && !cnt_dec[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (cnt_dec[i] && !cnt_inc[i] && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < S_COUNT; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < S_COUNT; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end
`else
  assign elig = s_if.ar_valid;
`endif

endmodule

// File: tb/tb_taxi_axi_rd_arb.sv
// Bench for taxi_axi_rd_arb: directed phases with literal checks plus a queue-free reference model
// compared against the four-requester instance every cycle; a three-requester instance covers the sink case.
module tb_taxi_axi_rd_arb;
  localparam int S  = 4;
  localparam int MO = 2;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  taxi_axi_rd_arb_if #(.N(S), .ADDR_W(32), .DATA_W(32), .ID_W(8))  s_if ();
  taxi_axi_rd_arb_if #(.N(1), .ADDR_W(32), .DATA_W(32), .ID_W(10)) m_if ();
  taxi_axi_rd_arb_if #(.N(3), .ADDR_W(32), .DATA_W(32), .ID_W(8))  s3_if ();
  taxi_axi_rd_arb_if #(.N(1), .ADDR_W(32), .DATA_W(32), .ID_W(10)) m3_if ();

  taxi_axi_rd_arb #(.S_COUNT(S), .ADDR_W(32), .DATA_W(32), .S_ID_W(8), .MAX_OUTSTANDING(MO)) dut (
    .clk  (clk),
    .rst  (rst),
    .s_if (s_if),
    .m_if (m_if)
  );

  taxi_axi_rd_arb #(.S_COUNT(3), .ADDR_W(32), .DATA_W(32), .S_ID_W(8), .MAX_OUTSTANDING(MO)) dut3 (
    .clk  (clk),
    .rst  (rst),
    .s_if (s3_if),
    .m_if (m3_if)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, want);
    end
  endtask

  function automatic int onehot_idx(input logic [S-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < S; i++) if (v[i]) r = i;
    return r;
  endfunction

  // ---------------- reference model ----------------
  bit          md_full;
  logic [9:0]  md_id;
  logic [31:0] md_addr;
  logic [7:0]  md_len;
  int          md_last;
  int          md_cnt [S];

  function automatic bit under_limit(input int c);
`ifdef TAXI_AXI_RD_ARB_LIMIT_EN
    return md_cnt[c] < MO;
`else
    return 1'b1;
`endif
  endfunction

  initial begin : model
    bit          n_full;
    logic [9:0]  n_id;
    logic [31:0] n_addr;
    logic [7:0]  n_len;
    int          n_last;
    int          n_cnt [S];
    int          g;
    int          sel;
    bit          free;
    bit          inc_hit;
    logic [S-1:0] exp_rdy;
    md_full = 0; md_id = '0; md_addr = '0; md_len = '0; md_last = S - 1;
    for (int i = 0; i < S; i++) md_cnt[i] = 0;
    forever begin
      @(negedge clk);
      n_id = md_id; n_addr = md_addr; n_len = md_len;
      if (rst) begin
        chk("rst_m_ar_valid", m_if.ar_valid, 0);
        chk("rst_s_ar_ready", s_if.ar_ready, 0);
        chk("rst_m_ar_addr", m_if.ar_addr, 0);
        n_full = 0; n_last = S - 1; n_id = '0; n_addr = '0; n_len = '0;
        for (int i = 0; i < S; i++) n_cnt[i] = 0;
      end else begin
        chk("m_ar_valid", m_if.ar_valid, md_full);
        if (md_full) begin
          chk("m_ar_id", m_if.ar_id, md_id);
          chk("m_ar_addr", m_if.ar_addr, md_addr);
          chk("m_ar_len", m_if.ar_len, md_len);
        end
        free = !md_full || m_if.ar_ready[0];
        g = -1;
        for (int step = 1; step <= S; step++) begin
          if (g < 0 && s_if.ar_valid[(md_last + step) % S] && under_limit((md_last + step) % S))
            g = (md_last + step) % S;
        end
        exp_rdy = (free && g >= 0) ? (S'(1) << g) : '0;
        chk("s_ar_ready", s_if.ar_ready, exp_rdy);
        sel = int'(m_if.r_id[9:8]);
        chk("s_r_valid", s_if.r_valid, m_if.r_valid[0] ? (S'(1) << sel) : '0);
        chk("m_r_ready", m_if.r_ready, s_if.r_ready[sel]);
        if (m_if.r_valid[0]) begin
          chk("s_r_id", s_if.r_id[8*sel +: 8], m_if.r_id[7:0]);
          chk("s_r_data", s_if.r_data[32*sel +: 32], m_if.r_data);
        end
        n_full = md_full && !m_if.ar_ready[0];
        n_last = md_last;
        for (int i = 0; i < S; i++) n_cnt[i] = md_cnt[i];
        inc_hit = 0;
        if (exp_rdy != '0) begin
          n_full = 1;
          n_id   = {2'(g), s_if.ar_id[8*g +: 8]};
          n_addr = s_if.ar_addr[32*g +: 32];
          n_len  = s_if.ar_len[8*g +: 8];
          n_last = g;
          n_cnt[g] = md_cnt[g] + 1;
          inc_hit = (g == sel);
        end
        if (m_if.r_valid[0] && s_if.r_ready[sel] && m_if.r_last[0]) begin
          if (inc_hit) n_cnt[sel] = md_cnt[sel];
          else if (md_cnt[sel] > 0) n_cnt[sel] = md_cnt[sel] - 1;
        end
      end
      @(posedge clk);
      md_full = n_full; md_id = n_id; md_addr = n_addr; md_len = n_len; md_last = n_last;
      for (int i = 0; i < S; i++) md_cnt[i] = n_cnt[i];
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic r_last_beat(input int idx);
    m_if.r_valid = 1'b1;
    m_if.r_id    = {2'(idx), 8'(8'h10 + idx)};
    m_if.r_data  = 32'hD000_0000 + 32'(idx);
    m_if.r_last  = 1'b1;
    s_if.r_ready = '1;
    next_cycle();
    m_if.r_valid = 1'b0;
    m_if.r_last  = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin : stim
    int got;
    int hs_cnt;
    logic [S-1:0] lim_d;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    for (int i = 0; i < S; i++) begin
      s_if.ar_id[8*i +: 8]     = 8'(8'h10 + i);
      s_if.ar_addr[32*i +: 32] = 32'h1000_0000 + 32'(i) * 32'h10;
      s_if.ar_len[8*i +: 8]    = 8'(i + 1);
      s_if.ar_size[3*i +: 3]   = 3'd2;
      s_if.ar_burst[2*i +: 2]  = 2'd1;
    end
    s_if.ar_valid = '1;
    s_if.r_ready  = '0;
    m_if.ar_ready = 1'b1;
    m_if.r_id = '0; m_if.r_data = '0; m_if.r_resp = '0; m_if.r_last = 1'b0; m_if.r_valid = 1'b0;
    s3_if.ar_id = '0; s3_if.ar_addr = '0; s3_if.ar_len = '0; s3_if.ar_size = '0; s3_if.ar_burst = '0;
    s3_if.ar_valid = '0; s3_if.r_ready = '0;
    m3_if.ar_ready = 1'b0;
    m3_if.r_id = '0; m3_if.r_data = '0; m3_if.r_resp = '0; m3_if.r_last = 1'b0; m3_if.r_valid = 1'b0;

    // reset held with every requester asking
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_s_ar_ready", s_if.ar_ready, 4'b0000);
    chk("reset_m_ar_valid", m_if.ar_valid, 1'b0);
    next_cycle();
    rst = 1'b0;

    // round robin from requester 0
    for (int k = 0; k < S; k++) begin
      @(negedge clk);
      got = onehot_idx(s_if.ar_ready);
      chk($sformatf("rr_grant_%0d", k), 32'(got), 32'(k));
      if (k >= 1) chk($sformatf("rr_m_valid_%0d", k), m_if.ar_valid, 1'b1);
      if (k == 1) chk("first_id_upper", m_if.ar_id[9:8], 2'd0);
      next_cycle();
    end
    s_if.ar_valid = '0;
    @(negedge clk);
    chk("rr_last_id", m_if.ar_id, {2'd3, 8'h13});
    next_cycle();
    for (int i = 0; i < S; i++) r_last_beat(i);
    s_if.r_ready = '0;

    // backpressure with requester 2 pending
    m_if.ar_ready = 1'b0;
    s_if.ar_valid = 4'b0100;
    @(negedge clk);
    chk("bp_first_grant", s_if.ar_ready, 4'b0100);
    next_cycle();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_s_ar_ready", s_if.ar_ready, 4'b0000);
      chk("bp_m_ar_addr", m_if.ar_addr, 32'h1000_0020);
      chk("bp_m_ar_id", m_if.ar_id, {2'd2, 8'h12});
      next_cycle();
    end
    m_if.ar_ready = 1'b1;
    hs_cnt = 0;
    @(negedge clk);
    if (s_if.ar_ready != '0) hs_cnt++;
    next_cycle();
    s_if.ar_valid = '0;
    @(negedge clk);
    if (s_if.ar_ready != '0) hs_cnt++;
    chk("bp_release_hs", 32'(hs_cnt), 32'd1);
    next_cycle();
    r_last_beat(2);
    r_last_beat(2);
    s_if.r_ready = '0;

    // R routing by upper ID bits, and the out-of-range sink on the 3-requester instance
    m_if.r_valid  = 1'b1;
    m_if.r_id     = {2'd3, 8'h5A};
    m_if.r_data   = 32'hCAFE_0003;
    s_if.r_ready  = 4'b1000;
    m3_if.r_valid = 1'b1;
    m3_if.r_id    = {2'd3, 8'h5A};
    @(negedge clk);
    chk("route_s_r_valid", s_if.r_valid, 4'b1000);
    chk("route_s_r_id3", s_if.r_id[31:24], 8'h5A);
    chk("route_m_r_ready_hi", m_if.r_ready, 1'b1);
    chk("sink_m_r_ready", m3_if.r_ready, 1'b1);
    chk("sink_s_r_valid", s3_if.r_valid, 3'b000);
    next_cycle();
    s_if.r_ready = 4'b0111;
    @(negedge clk);
    chk("route_m_r_ready_lo", m_if.r_ready, 1'b0);
    next_cycle();
    m_if.r_valid = 1'b0; m3_if.r_valid = 1'b0; s_if.r_ready = '0;

    // outstanding limit on requester 1
`ifdef TAXI_AXI_RD_ARB_LIMIT_EN
    lim_d = 4'b0000;
`else
    lim_d = 4'b0010;
`endif
    s_if.ar_valid = 4'b0010;
    @(negedge clk);
    chk("lim_a", s_if.ar_ready, 4'b0010);
    next_cycle();
    @(negedge clk);
    chk("lim_b", s_if.ar_ready, 4'b0010);
    next_cycle();
    s_if.ar_valid = 4'b0110;
    @(negedge clk);
    chk("lim_c_skip", s_if.ar_ready, 4'b0100);
    next_cycle();
    s_if.ar_valid = 4'b0010;
    @(negedge clk);
    chk("lim_d_stall", s_if.ar_ready, lim_d);
    next_cycle();
    m_if.r_valid = 1'b1;
    m_if.r_id    = {2'd1, 8'h11};
    m_if.r_last  = 1'b1;
    s_if.r_ready = 4'b0010;
    @(negedge clk);
    chk("lim_e_same_cycle", s_if.ar_ready, lim_d);
    next_cycle();
    m_if.r_valid = 1'b0;
    m_if.r_last  = 1'b0;
    @(negedge clk);
    chk("lim_f_reenable", s_if.ar_ready, 4'b0010);
    next_cycle();
    s_if.ar_valid = '0;
    s_if.r_ready  = '0;
    repeat (3) next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/taxi_axi_rd_arb.md
# taxi_axi_rd_arb

Round-robin read-channel arbiter that shares one AXI4 read master port among `S_COUNT` requesters. It sits upstream of the single-slave-port AXI interconnect, so several DMA/engine clients can use one interconnect slave port. AR requests are arbitrated and registered. Requester index is prepended to the ARID, and R beats are routed back by the upper ID bits. A per-requester outstanding-burst counter throttles each client.

## Interface
Parameters:
- `S_COUNT`, 4: number of requesters (2–16).
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: read data width.
- `S_ID_W`, 8: requester ID width.
- `M_ID_W`, `S_ID_W+$clog2(S_COUNT)`: master ID width. Requester index occupies bits `[M_ID_W-1:S_ID_W]`.
- `MAX_OUTSTANDING`, 8: maximum outstanding bursts per requester (1–255).

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `s_ar_id`  in  `S_COUNT*S_ID_W`  per-requester ARID.
- `s_ar_addr`  in  `S_COUNT*ADDR_W`  ARADDR.
- `s_ar_len`  in  `S_COUNT*8`  ARLEN.
- `s_ar_size`  in  `S_COUNT*3`  ARSIZE.
- `s_ar_burst`  in  `S_COUNT*2`  ARBURST.
- `s_ar_valid`  in  `S_COUNT`  ARVALID.
- `s_ar_ready`  out  `S_COUNT`  ARREADY.
- `s_r_id`  out  `S_COUNT*S_ID_W`  RID. This is the lower `S_ID_W` bits of `m_r_id`, broadcast to all requesters.
- `s_r_data`  out  `S_COUNT*DATA_W`  RDATA, broadcast.
- `s_r_resp`  out  `S_COUNT*2`  RRESP, broadcast.
- `s_r_last`  out  `S_COUNT`  RLAST, broadcast.
- `s_r_valid`  out  `S_COUNT`  RVALID, routed.
- `s_r_ready`  in  `S_COUNT`  RREADY.
- `m_ar_id`  out  `M_ID_W`  `{index, s_ar_id}`.
- `m_ar_addr` / `m_ar_len` / `m_ar_size` / `m_ar_burst`  out  `ADDR_W`/8/3/2  registered AR fields.
- `m_ar_valid`  out  1;  `m_ar_ready`  in  1.
- `m_r_id`  in  `M_ID_W`;  `m_r_data`  in  `DATA_W`;  `m_r_resp`  in  2;  `m_r_last`  in  1;  `m_r_valid`  in  1;  `m_r_ready`  out  1.

## Operation
- The AR output is a one-entry holding register, `ar_full`. When `ar_full` is set it drives `m_ar_*`, and `m_ar_valid = ar_full`.
- Eligible requester: `s_ar_valid[i]` is high and, when limiting is enabled, `cnt[i] < MAX_OUTSTANDING`.
- Arbitration happens every cycle in which the register is free (`!ar_full || m_ar_ready`).
  - Grant the first eligible requester, searching `last+1, last+2, …` modulo `S_COUNT`.
  - `s_ar_ready[g]` is asserted combinationally for the granted index only.
  - On the handshake, load the register, set `last = g`, and increment `cnt[g]`.
- Each grant transfers exactly one AR. There is no lock across bursts.
- R routing is combinational:
  - `sel = m_r_id[M_ID_W-1:S_ID_W]`.
  - `s_r_valid[i] = m_r_valid && sel==i`.
  - `m_r_ready = s_r_ready[sel]`.
- If `sel >= S_COUNT`, the beat is sunk: `m_r_ready = 1` and no `s_r_valid` is asserted.
- Counters: `cnt[i]` decrements on an R handshake with `m_r_last` and `sel==i`.
  - Simultaneous increment and decrement on the same index leaves `cnt[i]` unchanged.
  - Width is `$clog2(MAX_OUTSTANDING+1)`.
  - Decrement at 0 saturates at 0. This is protocol-violation tolerance only.

## Timing
- Reset values:
  - `m_ar_valid = 0`, and all `m_ar_*` fields are 0.
  - `s_ar_ready = 0` while `rst` is high.
  - All `cnt = 0`.
  - `last = S_COUNT-1`, so requester 0 has first priority.
- AR latency: `s_ar_valid`/`s_ar_ready` handshake at edge N gives `m_ar_valid = 1` from after edge N.
- Throughput is one AR per cycle under back-to-back `m_ar_ready`.
- If `m_ar_ready` stays low, `m_ar_*` stays stable and no new grant is issued.
- R path: zero latency, fully combinational, no buffering.
- A requester's `s_ar_valid` dropping without a handshake causes no state change.
- A requester at its limit is skipped and the next eligible one is granted in the same cycle.
- Reset mid-burst discards the held AR and all counts. Downstream must also be reset.

## Configuration
- `TAXI_AXI_RD_ARB_LIMIT_EN`
  - Defined: outstanding counters are built and gate eligibility as above.
  - Undefined: counters are not instantiated, eligibility is `s_ar_valid[i]` only, and `MAX_OUTSTANDING` is ignored.

## Test plan
- **Reset:**
  - Stimulus: assert `rst` while all `s_ar_valid = 1`.
  - Required: `m_ar_valid = 0` and `s_ar_ready = 0`.
  - After release, the first `m_ar_id` upper bits are 0.
- **Round-robin:**
  - Stimulus: `S_COUNT = 4`, all requesters continuously valid, `m_ar_ready = 1`.
  - Required: grants follow 0,1,2,3,0,… with `m_ar_valid` high every cycle.
- **Backpressure:**
  - Stimulus: hold `m_ar_ready = 0` for 5 cycles with requester 2 pending.
  - Required: `m_ar_addr`/`m_ar_id` remain stable and `s_ar_ready` stays all zero.
  - Release gives exactly one handshake.
- **ID routing:**
  - Stimulus: R beats with `m_r_id = {2'd3, 8'h5A}`.
  - Required: only `s_r_valid[3]` is high and `s_r_id[3] = 8'h5A`.
  - `m_r_ready` follows `s_r_ready[3]`.
  - `sel = 3` with `S_COUNT = 3` sinks the beat.
- **Limit (macro defined, `MAX_OUTSTANDING = 2`):**
  - Stimulus: requester 1 issues 2 ARs with no R returned.
  - Required: the third AR stalls while others are still granted.
  - A `m_r_last` beat for index 1 re-enables requester 1 on the next cycle.
- **Limit (macro undefined):**
  - Stimulus: same as the previous scenario.
  - Required: requester 1 issues unlimited ARs.
